// File: rtl/mul_unit_pkg.sv
// Shared definitions for the SPECIAL2 multiply/count unit: widths, function
// codes, FSM state encodings and the latched multiply request.
package mul_unit_pkg;

   localparam int unsigned W    = 32;
   localparam int unsigned PW   = 2 * W;
   localparam int unsigned CNTW = $clog2(W);
   localparam int unsigned LZW  = $clog2(W) + 1;

   // SPECIAL2 function codes
   localparam logic [5:0] FN_MADD  = 6'h00;
   localparam logic [5:0] FN_MADDU = 6'h01;
   localparam logic [5:0] FN_MUL   = 6'h02;
   localparam logic [5:0] FN_MSUB  = 6'h04;
   localparam logic [5:0] FN_MSUBU = 6'h05;
   localparam logic [5:0] FN_CLZ   = 6'h20;
   localparam logic [5:0] FN_CLO   = 6'h21;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;

   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2
   } acc_op_t;

   typedef struct packed {
      logic          neg;
      acc_op_t       acc;
   } mul_ctl_t;

   // Magnitude of a two's complement word; the most negative value maps to 2^(W-1).
   function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
      return x[W-1] ? W'(~x + W'(1)) : x;
   endfunction

endpackage

// File: rtl/mul_unit_clz.sv
// Leading-zero counter; an all-zero input yields N.
module clz_count
   import mul_unit_pkg::*;
#(
   parameter int unsigned N = W
) (
   input  logic [N-1:0]         a,
   output logic [$clog2(N):0]   count
);

   localparam int unsigned NC = $clog2(N) + 1;

   logic found;

   always_comb begin
      count = NC'(N);
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!found && a[i]) begin
            count = NC'(N - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_unit.sv
// SPECIAL2 execute unit: radix-2 shift-add multiplier with HI/LO accumulator,
// plus single-cycle CLO/CLZ.
module mul_unit
   import mul_unit_pkg::*;
(
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic [5:0]    Func,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   output logic          Busy,
   output logic          Done,
   output logic [W-1:0]  Result,
   output logic [W-1:0]  HI,
   output logic [W-1:0]  LO
);

   logic [1:0]      state,  state_n;
   logic [CNTW-1:0] cnt,    cnt_n;
   logic [PW-1:0]   mcand,  mcand_n;
   logic [W-1:0]    mplier, mplier_n;
   logic [PW-1:0]   prod,   prod_n;
   mul_ctl_t        ctl,    ctl_n;
   logic            busy_n, done_n;
   logic [W-1:0]    result_n, hi_n, lo_n;

   logic            signed_op;
   logic [W-1:0]    lz_in;
   logic [LZW-1:0]  lz_cnt;
   logic [PW-1:0]   p_signed;
   logic [PW-1:0]   acc_sum;
   logic [PW-1:0]   acc_dif;

   assign signed_op = (Func == FN_MUL) || (Func == FN_MADD) || (Func == FN_MSUB);

   // CLO counts leading ones by counting leading zeros of the complement
   assign lz_in = (Func == FN_CLO) ? ~A : A;

   clz_count #(.N(W)) u_clz (
      .a     (lz_in),
      .count (lz_cnt)
   );

   assign p_signed = ctl.neg ? PW'(~prod + PW'(1)) : prod;
   assign acc_sum  = {HI, LO} + p_signed;
   assign acc_dif  = {HI, LO} - p_signed;

   // Next-state and registered-output logic
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mcand_n  = mcand;
      mplier_n = mplier;
      prod_n   = prod;
      ctl_n    = ctl;
      result_n = Result;
      hi_n     = HI;
      lo_n     = LO;
      done_n   = 1'b0;

      case (state)
         S_IDLE: begin
            if (Start) begin
               case (Func)
                  FN_MUL, FN_MADD, FN_MADDU, FN_MSUB, FN_MSUBU: begin
                     mcand_n   = PW'(signed_op ? abs_w(A) : A);
                     mplier_n  = signed_op ? abs_w(B) : B;
                     ctl_n.neg = signed_op & (A[W-1] ^ B[W-1]);
                     if (Func == FN_MUL)
                        ctl_n.acc = ACC_NONE;
                     else if ((Func == FN_MADD) || (Func == FN_MADDU))
                        ctl_n.acc = ACC_ADD;
                     else
                        ctl_n.acc = ACC_SUB;
                     prod_n  = '0;
                     cnt_n   = '0;
                     state_n = S_CALC;
                  end
                  FN_CLO, FN_CLZ: begin
                     result_n = W'(lz_cnt);
                     done_n   = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         S_CALC: begin
            if (mplier[0])
               prod_n = prod + mcand;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + CNTW'(1);
            if (cnt == CNTW'(W - 1))
               state_n = S_ACC;
         end

         S_ACC: begin
            case (ctl.acc)
               ACC_ADD: begin
                  {hi_n, lo_n} = acc_sum;
                  result_n     = acc_sum[W-1:0];
               end
               ACC_SUB: begin
                  {hi_n, lo_n} = acc_dif;
                  result_n     = acc_dif[W-1:0];
               end
               default: result_n = p_signed[W-1:0];
            endcase
            done_n  = 1'b1;
            state_n = S_IDLE;
         end

         default: state_n = S_IDLE;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         ctl    <= '{neg: 1'b0, acc: ACC_NONE};
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Result <= '0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mcand  <= mcand_n;
         mplier <= mplier_n;
         prod   <= prod_n;
         ctl    <= ctl_n;
         Busy   <= busy_n;
         Done   <= done_n;
         Result <= result_n;
         HI     <= hi_n;
         LO     <= lo_n;
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: vector table plus hand-written corner sequences.
module tb_mul_unit;
   import mul_unit_pkg::*;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Start;
   logic [5:0]    Func;
   logic [31:0]   A, B;
   logic          Busy, Done;
   logic [31:0]   Result, HI, LO;

   always #5 Clock = ~Clock;

   mul_unit dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Func   (Func),
      .A      (A),
      .B      (B),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result),
      .HI     (HI),
      .LO     (LO)
   );

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   typedef struct {
      bit          rst;
      logic [5:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   exp_t sb[$];
   vec_t tv[11];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b1;
      Start = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      check32("reset_state", {27'd0, Busy, Done, 3'd0}, 32'd0);
      check32("reset_result", Result, 32'd0);
      check32("reset_hilo", HI | LO, 32'd0);
   endtask

   // Called at a negedge; drives Start for one cycle and waits for Done.
   task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [31:0] hi,
                        input logic [31:0] lo, input int lat, input bit poke);
      exp_t e;
      int   cyc;
      int   busy_bad;
      bit   got;
      e.res = res; e.hi = hi; e.lo = lo; e.lat = lat;
      sb.push_back(e);
      Start = 1'b1; Func = f; A = a; B = b;
      @(negedge Clock);
      Start = 1'b0;
      cyc = 1; busy_bad = 0; got = 1'b0;
      while (cyc <= 80) begin
         if (Done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (Busy !== 1'b1) busy_bad++;
         if (poke && (cyc == 5 || cyc == 20)) begin
            Start = 1'b1; Func = FN_MADD; A = 32'hFFFF_FFFF; B = 32'h1234_5678;
         end else begin
            Start = 1'b0;
         end
         @(negedge Clock);
         cyc++;
      end
      Start = 1'b0;
      e = sb.pop_front();
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: no Done within %0d cycles", name, cyc - 1);
      end else begin
         check32({name, "_latency"}, 32'(cyc), 32'(e.lat));
         check32({name, "_result"}, Result, e.res);
         check32({name, "_hi"}, HI, e.hi);
         check32({name, "_lo"}, LO, e.lo);
         check32({name, "_busy"}, {31'd0, Busy}, 32'd0);
         check32({name, "_busy_window"}, 32'(busy_bad), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int done_seen;
      int busy_seen;

      Reset = 1'b0; Start = 1'b0; Func = 6'h00; A = '0; B = '0;

      tv[0]  = '{1'b1, FN_MUL,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'h0,         32'h0,         34};
      tv[1]  = '{1'b1, FN_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 34};
      tv[2]  = '{1'b0, FN_MADDU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
      tv[3]  = '{1'b1, FN_MSUB,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'h0000_0000, 34};
      tv[4]  = '{1'b0, FN_CLZ,   32'h0001_0000, 32'd0,         32'd15,        32'hC000_0000, 32'h0000_0000, 1};
      tv[5]  = '{1'b0, FN_CLZ,   32'h0000_0000, 32'd0,         32'd32,        32'hC000_0000, 32'h0000_0000, 1};
      tv[6]  = '{1'b0, FN_CLO,   32'hFFFF_FFFF, 32'd0,         32'd32,        32'hC000_0000, 32'h0000_0000, 1};
      tv[7]  = '{1'b0, FN_CLO,   32'hF000_0000, 32'd0,         32'd4,         32'hC000_0000, 32'h0000_0000, 1};
      tv[8]  = '{1'b0, FN_MADD,  32'hFFFF_FFFE, 32'd5,         32'hFFFF_FFF6, 32'hBFFF_FFFF, 32'hFFFF_FFF6, 34};
      tv[9]  = '{1'b0, FN_MSUBU, 32'd2,         32'd3,         32'hFFFF_FFF0, 32'hBFFF_FFFF, 32'hFFFF_FFF0, 34};
      tv[10] = '{1'b0, FN_MUL,   32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hBFFF_FFFF, 32'hFFFF_FFF0, 34};

      for (int i = 0; i < 11; i++) begin
         if (tv[i].rst) do_reset();
         issue($sformatf("vec%0d", i), tv[i].func, tv[i].a, tv[i].b,
               tv[i].res, tv[i].hi, tv[i].lo, tv[i].lat, 1'b0);
      end

      // Reset during a MADD: abort, no Done, accumulator cleared
      Start = 1'b1; Func = FN_MADD; A = 32'd3; B = 32'd4;
      @(negedge Clock);
      Start = 1'b0;
      done_seen = 0;
      for (int c = 1; c < 10; c++) begin
         if (Done === 1'b1) done_seen++;
         @(negedge Clock);
      end
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check32("abort_busy", {31'd0, Busy}, 32'd0);
      check32("abort_done", {31'd0, Done}, 32'd0);
      check32("abort_hi", HI, 32'd0);
      check32("abort_lo", LO, 32'd0);
      for (int c = 0; c < 40; c++) begin
         if (Done === 1'b1) done_seen++;
         @(negedge Clock);
      end
      check32("abort_no_done", 32'(done_seen), 32'd0);

      issue("maddu_small", FN_MADDU, 32'd1, 32'd5, 32'd5, 32'd0, 32'd5, 34, 1'b0);

      // Invalid function code: ignored entirely
      Start = 1'b1; Func = 6'h3F; A = 32'h1234_5678; B = 32'h9;
      @(negedge Clock);
      Start = 1'b0;
      done_seen = 0; busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (Done === 1'b1) done_seen++;
         if (Busy === 1'b1) busy_seen++;
         @(negedge Clock);
      end
      check32("invalid_no_done", 32'(done_seen), 32'd0);
      check32("invalid_no_busy", 32'(busy_seen), 32'd0);
      check32("invalid_result_held", Result, 32'd5);
      check32("invalid_hi", HI, 32'd0);
      check32("invalid_lo", LO, 32'd5);

      // Start pulses while busy must not disturb the running MUL
      issue("mul_poked", FN_MUL, 32'd5, 32'd6, 32'd30, 32'd0, 32'd5, 34, 1'b1);

      // Back-to-back: second Start lands in the Done cycle of the first
      issue("mul_first", FN_MUL, 32'd9, 32'd9, 32'd81, 32'd0, 32'd5, 34, 1'b0);
      issue("mul_b2b", FN_MUL, 32'd2, 32'd3, 32'd6, 32'd0, 32'd5, 34, 1'b0);
      issue("clz_b2b", FN_CLZ, 32'h0000_0001, 32'd0, 32'd31, 32'd0, 32'd5, 1, 1'b0);

      @(negedge Clock);
      check32("final_done_pulse", {31'd0, Done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
